pipe_seg_adder: RTL and testbench
=================================

Name: pipe_seg_adder

Overview:
- Parametrised successor to the team's 8-bit combinational carry-ripple adder.
- Splits a WIDTH-bit add/subtract into SEGS equal slices and processes one slice per pipeline stage, passing the carry through a register between stages.
- Adds a valid/ready handshake and a subtract mode, and reports signed overflow.
- Sits in the datapath wherever a wide adder must meet timing at full throughput.

Parameters:
- WIDTH, 8, operand and result width in bits.
- SEGS, 2, number of slices and pipeline stages; 1 <= SEGS <= WIDTH; WIDTH % SEGS == 0 (elaboration error otherwise).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in when sub=0; borrow-in when sub=1.
- sub  input  1  0: x+y+cin; 1: x-y-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- carry  output  1  raw carry-out of MSB.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Slice width is SW = WIDTH/SEGS. Slice k covers bits [k*SW +: SW].
- Operation:
  - Effective B is y ^ {WIDTH{sub}}.
  - Initial carry c0 = cin ^ sub, so sub=1, cin=0 gives x-y and sub=1, cin=1 gives x-y-1.
  - carry is the raw MSB carry-out. For subtraction, carry=1 means no borrow.
  - ovf = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]).
- Pipeline enable: adv = !out_valid || out_ready. in_ready = adv (combinational).
- Transfer: an operand set transfers on a rising edge with in_valid && in_ready.
- Stage 0:
  - Captures slice 0 of the sum and its carry.
  - Captures the remaining operand slices of A and Beff, and sub.
  - Captures a valid bit.
- Stage k (k >= 1): on adv, adds slice k using the registered carry from stage k-1, and forwards the lower result slices, the remaining operand slices and the valid bit.
- Latency: operands accepted at edge t give out_valid=1 after edge t+SEGS-1, i.e. SEGS cycles. SEGS=1 is a registered ripple adder with 1-cycle latency.
- Throughput: one operation per cycle when out_ready=1. Results leave in acceptance order.
- Stall: when out_valid && !out_ready, all stages freeze, in_ready=0, and sum/carry/ovf/out_valid hold exactly. Nothing is lost or duplicated.
- Bubbles: invalid slots advance like data and are not compressed. While stalled, bubbles behind the head stay in place.
- Output side: sum, carry and ovf are driven from the final stage registers and are meaningful only while out_valid=1. They hold their last value otherwise.
- Reset (rst_n=0 at a rising edge) overrides everything:
  - All valid bits, data, carry and overflow registers are cleared to 0.
  - Outputs after reset: out_valid=0, sum=0, carry=0, ovf=0, in_ready=1.
- Reset mid-operation discards all in-flight operations. No result appears for them afterwards.
- Inputs sampled in the reset cycle are ignored.
- Simultaneous events: an input transfer and an output transfer in the same cycle are legal and keep full throughput.
- Wrap-around: sums are modulo 2^WIDTH, with the excess reported only on carry.

Test Plan:
- Default params; x=8'hFF, y=8'h01, sub=0, cin=0 -> 2 cycles later out_valid=1, sum=8'h00, carry=1, ovf=0. Also x=8'h7F, y=8'h01 -> sum=8'h80, carry=0, ovf=1.
- Subtract: x=8'h05, y=8'h07, sub=1, cin=0 -> sum=8'hFE, carry=0, ovf=0. x=8'h80, y=8'h01, sub=1 -> sum=8'h7F, carry=1, ovf=1. x=8'h05, y=8'h02, sub=1, cin=1 -> sum=8'h02, carry=1.
- Streaming: 12 random operand pairs on consecutive cycles with out_ready=1 -> 12 results on consecutive cycles, in order, matching the golden model {carry,sum}, with 0 errors.
- Backpressure: fill the pipeline, then hold out_ready=0 for 3 cycles -> in_ready=0 and sum/carry/ovf/out_valid held constant. On release, results drain in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 for 1 cycle with 2 operations in flight -> next cycle out_valid=0, sum=0, carry=0, ovf=0, in_ready=1, and neither in-flight result ever emerges.
- WIDTH=16, SEGS=4: x=16'hFFFF, y=16'h0001 -> after 4 cycles sum=16'h0000, carry=1, exercising carry propagation through all three stage registers. Repeat with SEGS=1: result after 1 cycle.

Source files
------------

// File: rtl/pipe_seg_adder.sv
// rtl/pipe_seg_adder.sv - segmented pipelined add/subtract with valid/ready handshake
// One SW-bit slice is summed per stage; the slice carry crosses each stage boundary in c_q.
module pipe_seg_adder #(
  parameter int WIDTH = 8,
  parameter int SEGS  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int SW = WIDTH / SEGS;

  if (SEGS < 1 || SEGS > WIDTH || (WIDTH % SEGS) != 0) begin : g_bad_params
    $error("pipe_seg_adder: SEGS must divide WIDTH and satisfy 1 <= SEGS <= WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] a_q [SEGS];
  logic [WIDTH-1:0] b_q [SEGS];
  logic [WIDTH-1:0] s_q [SEGS];
  logic [SEGS-1:0]  c_q;
  logic [SEGS-1:0]  v_q;

  logic [WIDTH-1:0] a_d [SEGS];
  logic [WIDTH-1:0] b_d [SEGS];
  logic [WIDTH-1:0] s_d [SEGS];
  logic [SEGS-1:0]  c_d;
  logic [SEGS-1:0]  v_d;
  logic [SEGS-1:0]  ci;
  logic [SW:0]      t;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    a_d[0] = x;
    b_d[0] = y ^ {WIDTH{sub}};
    s_d[0] = '0;
    v_d[0] = in_valid;
    ci[0]  = cin ^ sub;
    for (int k = 1; k < SEGS; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = s_q[k-1];
      v_d[k] = v_q[k-1];
      ci[k]  = c_q[k-1];
    end
    t   = '0;
    c_d = '0;
    // Each stage fills in its own slice on top of the lower slices already forwarded.
    for (int k = 0; k < SEGS; k++) begin
      t = {1'b0, a_d[k][k*SW +: SW]} + {1'b0, b_d[k][k*SW +: SW]} + {{SW{1'b0}}, ci[k]};
      s_d[k][k*SW +: SW] = t[SW-1:0];
      c_d[k] = t[SW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SEGS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < SEGS; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign out_valid = v_q[SEGS-1];
  assign sum       = s_q[SEGS-1];
  assign carry     = c_q[SEGS-1];
  assign ovf       = (a_q[SEGS-1][WIDTH-1] == b_q[SEGS-1][WIDTH-1]) &&
                     (s_q[SEGS-1][WIDTH-1] != a_q[SEGS-1][WIDTH-1]);

endmodule

// File: tb/tb_pipe_seg_adder.sv
// tb/tb_pipe_seg_adder.sv - randomized self-checking bench for pipe_seg_adder
module tb_pipe_seg_adder;

  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, carry, ovf;
  logic [W-1:0] x, y, sum;

  logic         w_valid, w_cin, w_sub;
  logic [15:0]  wx, wy, w4_sum, w1_sum;
  logic         w4_in_ready, w4_out_valid, w4_carry, w4_ovf;
  logic         w1_in_ready, w1_out_valid, w1_carry, w1_ovf;

  pipe_seg_adder #(.WIDTH(W), .SEGS(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .ovf(ovf)
  );

  pipe_seg_adder #(.WIDTH(16), .SEGS(4)) u_dut_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w4_in_ready),
    .x(wx), .y(wy), .cin(w_cin), .sub(w_sub), .out_valid(w4_out_valid), .out_ready(1'b1),
    .sum(w4_sum), .carry(w4_carry), .ovf(w4_ovf)
  );

  pipe_seg_adder #(.WIDTH(16), .SEGS(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w1_in_ready),
    .x(wx), .y(wy), .cin(w_cin), .sub(w_sub), .out_valid(w1_out_valid), .out_ready(1'b1),
    .sum(w1_sum), .carry(w1_carry), .ovf(w1_ovf)
  );

  int          errors = 0;
  int          checks = 0;
  logic [17:0] exp_q[$];
  bit          popped;
  logic [17:0] pop_val;
  int          valid_ticks;
  bit          stalled_prev;
  logic [W+2:0] snap;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Golden result {ovf, carry, sum} from plain integer arithmetic on w-bit operands.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic su);
    longint m, h, ua, ub, sa, sb, r, sr;
    logic [15:0] s;
    logic c, o;
    m  = longint'(1) << w;
    h  = m / 2;
    ua = longint'(a);
    ub = longint'(b);
    r  = su ? ua - ub - longint'(ci) : ua + ub + longint'(ci);
    s  = 16'(r & (m - 1));
    c  = su ? (r >= 0) : (r >= m);
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    sr = su ? sa - sb - longint'(ci) : sa + sb + longint'(ci);
    o  = (sr >= h) || (sr < -h);
    return {o, c, s};
  endfunction

  task automatic tick(input bit rst, input bit iv, input logic [W-1:0] ix, input logic [W-1:0] iy,
                      input bit ic, input bit is, input bit ordy);
    logic [17:0] e;
    @(posedge clk);
    #1;
    rst_n = !rst; in_valid = iv; x = ix; y = iy; cin = ic; sub = is; out_ready = ordy;
    #1;
    popped = 0;
    if (stalled_prev) check_val("stall_hold", 32'({out_valid, carry, ovf, sum}), 32'(snap));
    stalled_prev = 0;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) valid_ticks++;
      if (out_valid && !out_ready) begin
        check_val("stall_in_ready", 32'(in_ready), 32'd0);
        stalled_prev = 1;
        snap = {out_valid, carry, ovf, sum};
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(W, 16'(ix), 16'(iy), ic, is));
      if (out_valid && out_ready) begin
        popped  = 1;
        pop_val = {ovf, carry, 8'h00, sum};
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("stream_result", 32'(pop_val), 32'(e));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, '0, 0, 0, 1);
  endtask

  task automatic rand_tick(input bit iv, input bit ordy);
    tick(0, iv, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ordy);
  endtask

  task automatic dir_op(input string tag, input logic [W-1:0] ix, input logic [W-1:0] iy,
                        input bit ic, input bit is, input logic [W-1:0] es, input bit ec, input bit eo);
    int lat;
    lat = 0;
    tick(0, 1, ix, iy, ic, is, 1);
    check_val({tag, "_accept"}, 32'(in_ready), 32'd1);
    do begin
      tick(0, 0, '0, '0, 0, 0, 1);
      lat++;
    end while (!popped && lat < 10);
    if (!popped) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_val({tag, "_latency"}, 32'(lat), 32'(S));
      check_val({tag, "_sum"}, 32'(pop_val[7:0]), 32'(es));
      check_val({tag, "_carry"}, 32'(pop_val[16]), 32'(ec));
      check_val({tag, "_ovf"}, 32'(pop_val[17]), 32'(eo));
    end
  endtask

  task automatic wide_op(input logic [15:0] ix, input logic [15:0] iy, input bit ic, input bit is,
                         output logic [15:0] s4, output bit c4);
    logic [17:0] e;
    bit got4, got1;
    e = ref_add(16, ix, iy, ic, is);
    got4 = 0; got1 = 0; s4 = '0; c4 = 0;
    @(posedge clk);
    #1;
    w_valid = 1; wx = ix; wy = iy; w_cin = ic; w_sub = is;
    #1;
    check_val("w_in_ready", 32'({w4_in_ready, w1_in_ready}), 32'h3);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      w_valid = 0;
      #1;
      if (!got4 && w4_out_valid) begin
        got4 = 1;
        check_val("w4_latency", 32'(n), 32'd4);
        check_val("w4_result", 32'({w4_ovf, w4_carry, w4_sum}), 32'(e));
        s4 = w4_sum; c4 = w4_carry;
      end
      if (!got1 && w1_out_valid) begin
        got1 = 1;
        check_val("w1_latency", 32'(n), 32'd1);
        check_val("w1_result", 32'({w1_ovf, w1_carry, w1_sum}), 32'(e));
      end
    end
    if (!got4) check_val("w4_timeout", 32'd0, 32'd1);
    if (!got1) check_val("w1_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ws;
    bit          wc;
    rst_n = 0; in_valid = 0; x = '0; y = '0; cin = 0; sub = 0; out_ready = 1;
    w_valid = 0; wx = '0; wy = '0; w_cin = 0; w_sub = 0;
    stalled_prev = 0; valid_ticks = 0; popped = 0; pop_val = '0; snap = '0;

    tick(1, 1, 8'hAA, 8'h55, 1, 0, 1);
    tick(1, 1, 8'hAA, 8'h55, 1, 0, 1);
    idle(1);
    check_val("reset_out_valid", 32'(out_valid), 32'd0);
    check_val("reset_sum", 32'(sum), 32'd0);
    check_val("reset_carry", 32'(carry), 32'd0);
    check_val("reset_ovf", 32'(ovf), 32'd0);
    check_val("reset_in_ready", 32'(in_ready), 32'd1);

    wide_op(16'hFFFF, 16'h0001, 0, 0, ws, wc);
    check_val("w16_ffff_sum", 32'(ws), 32'h0);
    check_val("w16_ffff_carry", 32'(wc), 32'd1);
    for (int i = 0; i < 4; i++) wide_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ws, wc);

    dir_op("add_ff_01", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    dir_op("add_7f_01", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
    dir_op("sub_05_07", 8'h05, 8'h07, 0, 1, 8'hFE, 0, 0);
    dir_op("sub_80_01", 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);
    dir_op("sub_05_02_b", 8'h05, 8'h02, 1, 1, 8'h02, 1, 0);

    valid_ticks = 0;
    for (int i = 0; i < 12; i++) rand_tick(1, 1);
    idle(S);
    check_val("stream_consecutive", 32'(valid_ticks), 32'd12);
    check_val("stream_drained", 32'(exp_q.size()), 32'd0);

    rand_tick(1, 1);
    rand_tick(1, 1);
    rand_tick(1, 0);
    check_val("bp_full", 32'(out_valid), 32'd1);
    rand_tick(1, 0);
    rand_tick(1, 0);
    idle(4);
    check_val("bp_drained", 32'(exp_q.size()), 32'd0);

    rand_tick(1, 1);
    rand_tick(1, 1);
    tick(1, 1, 8'h12, 8'h34, 0, 0, 1);
    valid_ticks = 0;
    idle(1);
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_sum", 32'(sum), 32'd0);
    check_val("midrst_carry", 32'(carry), 32'd0);
    check_val("midrst_ovf", 32'(ovf), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);
    idle(5);
    check_val("midrst_no_ghost", 32'(valid_ticks), 32'd0);

    for (int i = 0; i < 300; i++) rand_tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    idle(10);
    check_val("random_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
